// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Four-master / single-slave arbiter for the core's internal bus.
//   m0 = JTAG debug, m1 = UART debug, m2 = core data (ex), m3 = core fetch (pc)
//   Fixed priority m0 > m1 > m2 > m3, resolved only while the bus is idle.
//   Once granted, the bus stays with the owner until the slave acknowledges.
//   The owner then gets a one-cycle registered response.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When it is defined, a BUSY phase that lasts TIMEOUT_CYCLES cycles without
//   a slave ack ends in an error response with zero read data.
//   When it is undefined, BUSY waits for the slave forever and every err
//   output is tied low.
//
// Parameters
//   TIMEOUT_CYCLES   BUSY cycles before a forced error response (1..255).
//                    It only has an effect when ARB_TIMEOUT_EN is defined.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   mN_req_i                 request from master N, held high until mN_ack_o
//   mN_we_i/addr_i/data_i    request payload from master N
//   mN_ack_o                 one-cycle response strobe to master N
//   mN_err_o                 error flag, qualified by mN_ack_o
//   mN_data_o                shared read-data register, qualified by mN_ack_o
//   s_req_o/we_o/addr_o/data_o  request to slave; all zero outside BUSY
//   s_ack_i, s_data_i        slave completion strobe and read data
//   grant_o                  index of the current (or most recent) owner
//   bus_hold_flag_o          stall request to the pipeline controller
// -----------------------------------------------------------------------------

// Response decode for one master. The owner sees ack/err only in the DONE
// cycle. Every other master sees both low at all times.
module bus_arbiter_port #(
  parameter logic [1:0] IDX = 2'd0
) (
  input  logic       done,
  input  logic [1:0] grant,
  input  logic       err,
  output logic       ack,
  output logic       rsp_err
);
  assign ack     = done && (grant == IDX);
  assign rsp_err = ack && err;
endmodule

module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_data_o,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_data_o,

  input  logic        m2_req_i,
  input  logic        m2_we_i,
  input  logic [31:0] m2_addr_i,
  input  logic [31:0] m2_data_i,
  output logic        m2_ack_o,
  output logic        m2_err_o,
  output logic [31:0] m2_data_o,

  input  logic        m3_req_i,
  input  logic        m3_we_i,
  input  logic [31:0] m3_addr_i,
  input  logic [31:0] m3_data_i,
  output logic        m3_ack_o,
  output logic        m3_err_o,
  output logic [31:0] m3_data_o,

  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_data_i,

  output logic [1:0]  grant_o,
  output logic        bus_hold_flag_o
);

  localparam int NUM_M = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Master request bundling
  // ---------------------------------------------------------------------------
  logic     [NUM_M-1:0] req;
  bus_req_t [NUM_M-1:0] mreq;

  assign req     = {m3_req_i, m2_req_i, m1_req_i, m0_req_i};
  assign mreq[0] = {m0_we_i, m0_addr_i, m0_data_i};
  assign mreq[1] = {m1_we_i, m1_addr_i, m1_data_i};
  assign mreq[2] = {m2_we_i, m2_addr_i, m2_data_i};
  assign mreq[3] = {m3_we_i, m3_addr_i, m3_data_i};

  // Lowest index wins. A zero vector is never passed in, because the caller
  // only arbitrates when at least one request is present.
  function automatic logic [1:0] prio(input logic [NUM_M-1:0] r);
    if (r[0])      return 2'd0;
    else if (r[1]) return 2'd1;
    else if (r[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      state, state_nxt;
  logic [1:0]  grant, grant_nxt;
  logic [31:0] rdata, rdata_nxt;
  logic        err_w;

`ifdef ARB_TIMEOUT_EN
  // Timeout fires at the end of the TIMEOUT_CYCLES-th BUSY cycle without an
  // ack. The counter value at the start of that cycle is TIMEOUT_CYCLES-1.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic       err, err_nxt;
  logic [7:0] cnt, cnt_nxt;

  assign err_w = err;
`else
  assign err_w = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      rdata <= rdata_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
      cnt <= '0;
    end else begin
      err <= err_nxt;
      cnt <= cnt_nxt;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rdata_nxt = rdata;
`ifdef ARB_TIMEOUT_EN
    err_nxt   = err;
    cnt_nxt   = cnt;
`endif
    case (state)
      IDLE: begin
        // Arbitration happens only here, so an owned bus is never preempted.
        if (|req) begin
          grant_nxt = prio(req);
          state_nxt = BUSY;
`ifdef ARB_TIMEOUT_EN
          cnt_nxt   = '0;
`endif
        end
      end
      BUSY: begin
        if (s_ack_i) begin
          // Read data is captured on writes too. The master ignores it.
          // An ack in the timeout cycle takes precedence over the timeout.
          rdata_nxt = s_data_i;
          state_nxt = DONE;
`ifdef ARB_TIMEOUT_EN
          err_nxt   = 1'b0;
`endif
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt == TMO_LAST) begin
          rdata_nxt = '0;
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt   = cnt + 8'd1;
        end
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Slave side: the owner's request is passed through combinationally during
  // BUSY. It is forced to zero in every other state.
  // ---------------------------------------------------------------------------
  logic     busy;
  bus_req_t sel;

  assign busy     = (state == BUSY);
  assign sel      = mreq[grant];
  assign s_req_o  = busy;
  assign s_we_o   = busy & sel.we;
  assign s_addr_o = busy ? sel.addr : '0;
  assign s_data_o = busy ? sel.data : '0;

  // ---------------------------------------------------------------------------
  // Master responses
  // ---------------------------------------------------------------------------
  logic             done;
  logic [NUM_M-1:0] ack;
  logic [NUM_M-1:0] rsp_err;

  assign done = (state == DONE);

  for (genvar i = 0; i < NUM_M; i++) begin : g_port
    bus_arbiter_port #(.IDX(2'(i))) u_port (
      .done    (done),
      .grant   (grant),
      .err     (err_w),
      .ack     (ack[i]),
      .rsp_err (rsp_err[i])
    );
  end

  assign m0_ack_o  = ack[0];
  assign m1_ack_o  = ack[1];
  assign m2_ack_o  = ack[2];
  assign m3_ack_o  = ack[3];
  assign m0_err_o  = rsp_err[0];
  assign m1_err_o  = rsp_err[1];
  assign m2_err_o  = rsp_err[2];
  assign m3_err_o  = rsp_err[3];
  assign m0_data_o = rdata;
  assign m1_data_o = rdata;
  assign m2_data_o = rdata;
  assign m3_data_o = rdata;

  assign grant_o = grant;

  // ---------------------------------------------------------------------------
  // Pipeline hold.
  // The first term covers a debug master (grant 0 or 1) holding the bus.
  // The second covers a core master waiting on the bus. The hold drops in the
  // cycle that core master receives its ack, so the pipeline can consume the
  // response without losing a cycle.
  // ---------------------------------------------------------------------------
  logic debug_own;

  assign debug_own       = (state != IDLE) && !grant[1];
  assign bus_hold_flag_o = debug_own
                         | (m2_req_i & ~ack[2])
                         | (m3_req_i & ~ack[3]);

endmodule
